// File: rtl/hazard_forward_ctrl_if.sv
// ============================================================================
// Module      : hazard_forward_ctrl_if
// Description : Bundles the decode-stage tags, pipeline control inputs and
//               hazard-controller outputs into one interface.
//               master : pipeline side. It drives the ID tags, branch_taken
//                        and ext_freeze, and receives stall/flush/forwarding.
//               slave  : the hazard_forward_ctrl block.
// Ports       : id_valid, id_rn, id_src2, id_two_src, id_uses_rn, id_dest,
//               id_wb_en, id_mem_r_en, branch_taken, ext_freeze (to slave);
//               stall, flush, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
//               (from slave)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_forward_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_uses_rn;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic             branch_taken;
  logic             ext_freeze;

  logic             stall;
  logic             flush;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rn, id_src2, id_two_src, id_uses_rn, id_dest,
           id_wb_en, id_mem_r_en, branch_taken, ext_freeze,
    input  stall, flush, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_src2, id_two_src, id_uses_rn, id_dest,
           id_wb_en, id_mem_r_en, branch_taken, ext_freeze,
    output stall, flush, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Pipeline hazard controller. A shadow scoreboard holds the
//               tags of every instruction after decode (entry 0 = EXE,
//               entry DEPTH-1 = WB). From it the block derives the IF/ID
//               stall, the branch flush and the EXE operand-forwarding
//               selects. It also keeps saturating stall/flush counters.
// Parameters  : REG_W - register address width
//               DEPTH - tracked post-decode stages, legal range 2..6
//               CNT_W - stall/flush counter width
// Macro       : HAZARD_FORWARD_EN - when defined, forwarding selects are
//               generated and stall covers only the load-use case. When
//               undefined, fwd_sel_* are 0 and stall covers every RAW match
//               in entries 0..DEPTH-2.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - hazard_forward_ctrl_if.slave (ID tags, branch_taken,
//                      ext_freeze in; stall, flush, fwd_sel_a/b,
//                      stall_cnt, flush_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_forward_ctrl #(
  parameter int REG_W = 4,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Scoreboard, one entry per post-decode stage
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0]            valid_q,    valid_d;
  logic [DEPTH-1:0]            wb_en_q,    wb_en_d;
  logic [DEPTH-1:0]            mem_r_en_q, mem_r_en_d;
  logic [DEPTH-1:0]            uses_rn_q,  uses_rn_d;
  logic [DEPTH-1:0]            two_src_q,  two_src_d;
  logic [DEPTH-1:0][REG_W-1:0] dest_q,     dest_d;
  logic [DEPTH-1:0][REG_W-1:0] rn_q,       rn_d;
  logic [DEPTH-1:0][REG_W-1:0] src2_q,     src2_d;

  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]            flush_cnt_q, flush_cnt_d;

  logic [DEPTH-2:0]            w_id_hit;
  logic                        w_hazard;
  logic                        w_stall;
  logic                        w_flush;
  logic [1:0]                  w_fwd_a;
  logic [1:0]                  w_fwd_b;

  // --------------------------------------------------------------------------
  // RAW match of the ID sources against the hazard window. The WB entry is
  // left out because the register file writes in the first half-cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_id_hit = '0;
    for (int k = 0; k < DEPTH-1; k++) begin
      w_id_hit[k] = valid_q[k] & wb_en_q[k] &
                    ((bus.id_uses_rn & (dest_q[k] == bus.id_rn)) |
                     (bus.id_two_src & (dest_q[k] == bus.id_src2)));
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Forwarding covers everything except a load still in EXE.
  assign w_hazard = bus.id_valid & w_id_hit[0] & mem_r_en_q[0];
`else
  assign w_hazard = bus.id_valid & (|w_id_hit);
`endif

  // A freeze holds the whole pipeline, so neither stall nor flush may act.
  // Flush wins over stall because the ID instruction is being killed anyway.
  assign w_flush = bus.branch_taken & ~bus.ext_freeze & ~rst;
  assign w_stall = w_hazard & ~bus.branch_taken & ~bus.ext_freeze & ~rst;

  // --------------------------------------------------------------------------
  // Forwarding selects for the instruction in EXE (entry 0)
  // --------------------------------------------------------------------------
`ifdef HAZARD_FORWARD_EN
  logic w_e1_a, w_e1_b;
  logic w_e2_a, w_e2_b;

  // A load in MEM has no ALU result to forward; it is picked up from WB on
  // the following cycle, after the load-use bubble.
  assign w_e1_a = valid_q[1] & wb_en_q[1] & ~mem_r_en_q[1] & (dest_q[1] == rn_q[0]);
  assign w_e1_b = valid_q[1] & wb_en_q[1] & ~mem_r_en_q[1] & (dest_q[1] == src2_q[0]);

  generate
    if (DEPTH >= 3) begin : g_fwd_wb
      assign w_e2_a = valid_q[2] & wb_en_q[2] & (dest_q[2] == rn_q[0]);
      assign w_e2_b = valid_q[2] & wb_en_q[2] & (dest_q[2] == src2_q[0]);
    end else begin : g_fwd_no_wb
      assign w_e2_a = 1'b0;
      assign w_e2_b = 1'b0;
    end
  endgenerate

  // The nearest producer wins. A bubble in EXE needs no operands.
  always_comb begin
    w_fwd_a = 2'd0;
    w_fwd_b = 2'd0;
    if (valid_q[0] & uses_rn_q[0]) begin
      if (w_e1_a)      w_fwd_a = 2'd1;
      else if (w_e2_a) w_fwd_a = 2'd2;
    end
    if (valid_q[0] & two_src_q[0]) begin
      if (w_e1_b)      w_fwd_b = 2'd1;
      else if (w_e2_b) w_fwd_b = 2'd2;
    end
  end
`else
  assign w_fwd_a = 2'd0;
  assign w_fwd_b = 2'd0;
`endif

  // --------------------------------------------------------------------------
  // Scoreboard advance and counter next-state
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d     = valid_q;
    wb_en_d     = wb_en_q;
    mem_r_en_d  = mem_r_en_q;
    uses_rn_d   = uses_rn_q;
    two_src_d   = two_src_q;
    dest_d      = dest_q;
    rn_d        = rn_q;
    src2_d      = src2_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!bus.ext_freeze) begin
      for (int k = DEPTH-1; k > 0; k--) begin
        valid_d[k]    = valid_q[k-1];
        wb_en_d[k]    = wb_en_q[k-1];
        mem_r_en_d[k] = mem_r_en_q[k-1];
        uses_rn_d[k]  = uses_rn_q[k-1];
        two_src_d[k]  = two_src_q[k-1];
        dest_d[k]     = dest_q[k-1];
        rn_d[k]       = rn_q[k-1];
        src2_d[k]     = src2_q[k-1];
      end
      // A stalled or killed ID instruction leaves a bubble in EXE.
      valid_d[0]    = bus.id_valid & ~w_stall & ~w_flush;
      wb_en_d[0]    = bus.id_wb_en;
      mem_r_en_d[0] = bus.id_mem_r_en;
      uses_rn_d[0]  = bus.id_uses_rn;
      two_src_d[0]  = bus.id_two_src;
      dest_d[0]     = bus.id_dest;
      rn_d[0]       = bus.id_rn;
      src2_d[0]     = bus.id_src2;

      if (w_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + c_cnt_one;
      if (w_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + c_cnt_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      wb_en_q     <= '0;
      mem_r_en_q  <= '0;
      uses_rn_q   <= '0;
      two_src_q   <= '0;
      dest_q      <= '0;
      rn_q        <= '0;
      src2_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wb_en_q     <= wb_en_d;
      mem_r_en_q  <= mem_r_en_d;
      uses_rn_q   <= uses_rn_d;
      two_src_q   <= two_src_d;
      dest_q      <= dest_d;
      rn_q        <= rn_d;
      src2_q      <= src2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The WB entry is only carried along for visibility; some tag bits are
  // never consulted depending on the build.
  logic w_unused_tags;
  assign w_unused_tags = ^{valid_q[DEPTH-1], wb_en_q[DEPTH-1], mem_r_en_q,
                           uses_rn_q, two_src_q, dest_q[DEPTH-1], rn_q,
                           src2_q, w_id_hit};

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.stall     = w_stall;
  assign bus.flush     = w_flush;
  assign bus.fwd_sel_a = w_fwd_a;
  assign bus.fwd_sel_b = w_fwd_b;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none

module tb_hazard_forward_ctrl;
  localparam int REG_W = 4;
  localparam int CNT_W = 4;
`ifdef HAZARD_FORWARD_EN
  localparam int DEPTH = 3;
  localparam bit FWD   = 1'b1;
`else
  localparam int DEPTH = 4;
  localparam bit FWD   = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_forward_ctrl #(.REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // --------------------------------------------------------------------------
  // Reference model: the pipeline as a list of in-flight instructions
  // --------------------------------------------------------------------------
  typedef struct {
    bit v, wb, ld, urn, two;
    int dest, rn, s2;
  } ins_t;

  ins_t pipe [DEPTH];
  ins_t cur;
  int   m_scnt = 0, m_fcnt = 0;
  bit   e_stall = 1'b0, e_flush = 1'b0;
  int   e_fa = 0, e_fb = 0;
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input ins_t p, input int r);
    return p.v && p.wb && (p.dest == r);
  endfunction

  function automatic ins_t id_now();
    ins_t t;
    t.v    = bus.id_valid;
    t.wb   = bus.id_wb_en;
    t.ld   = bus.id_mem_r_en;
    t.urn  = bus.id_uses_rn;
    t.two  = bus.id_two_src;
    t.dest = int'(bus.id_dest);
    t.rn   = int'(bus.id_rn);
    t.s2   = int'(bus.id_src2);
    return t;
  endfunction

  // Source of an EXE operand: nearest older producer; a load one stage ahead
  // cannot supply its value yet.
  function automatic int fsel(input bit used, input int r);
    if (!pipe[0].v || !used) return 0;
    if (writes(pipe[1], r) && !pipe[1].ld) return 1;
    if (writes(pipe[2], r)) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin
    cur     = id_now();
    e_flush = !rst && !bus.ext_freeze && bus.branch_taken;
    e_stall = 1'b0;
    if (!rst && !bus.ext_freeze && !bus.branch_taken && cur.v)
      for (int k = 0; k < DEPTH-1; k++)
        if ((cur.urn && writes(pipe[k], cur.rn)) || (cur.two && writes(pipe[k], cur.s2)))
          if (!FWD || (k == 0 && pipe[0].ld)) e_stall = 1'b1;
    e_fa = 0;
    e_fb = 0;
    if (FWD && !rst) begin
      e_fa = fsel(pipe[0].urn, pipe[0].rn);
      e_fb = fsel(pipe[0].two, pipe[0].s2);
    end
    check("model stall",     bus.stall,     e_stall);
    check("model flush",     bus.flush,     e_flush);
    check("model fwd_sel_a", bus.fwd_sel_a, e_fa);
    check("model fwd_sel_b", bus.fwd_sel_b, e_fb);
    check("model stall_cnt", bus.stall_cnt, rst ? 0 : m_scnt);
    check("model flush_cnt", bus.flush_cnt, rst ? 0 : m_fcnt);
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] = '{default: 0};
      m_scnt = 0;
      m_fcnt = 0;
    end else if (!bus.ext_freeze) begin
      if (e_stall && m_scnt < CNT_MAX) m_scnt++;
      if (e_flush && m_fcnt < CNT_MAX) m_fcnt++;
      for (int k = DEPTH-1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0]   = id_now();
      pipe[0].v = bus.id_valid && !e_stall && !e_flush;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic set_id(input bit v, input int dest, input bit wb, input bit ld,
                        input bit urn, input int rn, input bit two, input int s2);
    bus.id_valid    = v;
    bus.id_dest     = REG_W'(dest);
    bus.id_wb_en    = wb;
    bus.id_mem_r_en = ld;
    bus.id_uses_rn  = urn;
    bus.id_rn       = REG_W'(rn);
    bus.id_two_src  = two;
    bus.id_src2     = REG_W'(s2);
  endtask

  task automatic nop();                       set_id(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int d, input int n, input int m); set_id(1, d, 1, 0, 1, n, 1, m); endtask
  task automatic ldr(input int d, input int n);              set_id(1, d, 1, 1, 1, n, 0, 0); endtask
  task automatic mov(input int d, input int m);              set_id(1, d, 1, 0, 0, 0, 1, m); endtask
  task automatic ctl(input bit br, input bit frz);
    bus.branch_taken = br;
    bus.ext_freeze   = frz;
  endtask
  task automatic tick();  @(posedge clk); #1; endtask
  task automatic mid();   @(negedge clk);     endtask
  task automatic drain(); nop(); ctl(0, 0); repeat (DEPTH + 1) tick(); endtask

  bit hold, br_prev, frz_prev;

  initial begin
    nop();
    ctl(0, 0);
    rst = 1'b1;
    tick();
    mid();
    check("reset stall", bus.stall, 0);
    check("reset stall_cnt", bus.stall_cnt, 0);
    tick();
    rst = 1'b0;

`ifdef HAZARD_FORWARD_EN
    // ALU RAW back-to-back: forward from MEM
    alu(1, 2, 3); mid(); check("raw stall a", bus.stall, 0); tick();
    alu(2, 1, 3); mid(); check("raw stall b", bus.stall, 0); tick();
    nop(); mid();
    check("raw fwd_a mem", bus.fwd_sel_a, 1);
    check("raw fwd_b none", bus.fwd_sel_b, 0);
    drain();
    // ALU RAW with one independent instruction between: forward from WB
    alu(1, 2, 3); tick();
    mov(7, 8);    tick();
    alu(2, 1, 3); mid(); check("raw gap stall", bus.stall, 0); tick();
    nop(); mid();
    check("raw gap fwd_a wb", bus.fwd_sel_a, 2);
    drain();
    // Load-use: one-cycle stall, then both operands from WB
    ldr(4, 5); tick();
    alu(5, 4, 4); mid(); check("ldu stall", bus.stall, 1); tick();
    mid(); check("ldu stall released", bus.stall, 0); tick();
    nop(); mid();
    check("ldu fwd_a", bus.fwd_sel_a, 2);
    check("ldu fwd_b", bus.fwd_sel_b, 2);
    check("ldu stall_cnt", bus.stall_cnt, 1);
    drain();
    // Branch while ID is load-dependent: flush wins, ID killed
    ldr(4, 5); tick();
    ldr(6, 4); ctl(1, 0); mid();
    check("br flush", bus.flush, 1);
    check("br stall", bus.stall, 0);
    tick();
    ctl(0, 0); alu(7, 6, 6); mid();
    check("br killed no stall", bus.stall, 0);
    check("br flush_cnt", bus.flush_cnt, 1);
    check("br stall_cnt", bus.stall_cnt, 1);
    tick();
    drain();
    // Freeze during a load-use stall
    ldr(4, 5); tick();
    alu(5, 4, 4); ctl(0, 1);
    repeat (5) begin
      mid(); check("frz stall", bus.stall, 0); check("frz stall_cnt", bus.stall_cnt, 1); tick();
    end
    ctl(0, 0); mid(); check("frz release stall", bus.stall, 1); tick();
    mid(); check("frz after stall", bus.stall, 0); check("frz after cnt", bus.stall_cnt, 2); tick();
    drain();
    // Saturation: a chain of dependent loads stalls every other cycle
    ldr(1, 1); repeat (40) tick();
`else
    // No forwarding: producer in EXE stalls consumer for DEPTH-1 cycles
    alu(1, 2, 3); tick();
    alu(6, 1, 10);
    repeat (3) begin
      mid(); check("nofwd stall", bus.stall, 1); check("nofwd fwd_a", bus.fwd_sel_a, 0); tick();
    end
    mid();
    check("nofwd stall end", bus.stall, 0);
    check("nofwd stall_cnt", bus.stall_cnt, 3);
    check("nofwd fwd_b", bus.fwd_sel_b, 0);
    tick();
    drain();
    // Branch with dependent ID: flush wins, ID killed
    alu(1, 2, 3); tick();
    alu(9, 1, 1); ctl(1, 0); mid();
    check("br flush", bus.flush, 1);
    check("br stall", bus.stall, 0);
    tick();
    ctl(0, 0); alu(6, 9, 9); mid();
    check("br killed no stall", bus.stall, 0);
    check("br flush_cnt", bus.flush_cnt, 1);
    check("br stall_cnt", bus.stall_cnt, 3);
    tick();
    drain();
    // Freeze during a stall
    alu(4, 2, 3); tick();
    alu(5, 4, 4); ctl(0, 1);
    repeat (5) begin
      mid(); check("frz stall", bus.stall, 0); check("frz stall_cnt", bus.stall_cnt, 3); tick();
    end
    ctl(0, 0);
    repeat (3) begin
      mid(); check("frz release stall", bus.stall, 1); tick();
    end
    mid(); check("frz after stall", bus.stall, 0); check("frz after cnt", bus.stall_cnt, 6); tick();
    drain();
    // Saturation: a self-dependent instruction stalls three of every four cycles
    alu(1, 1, 1); repeat (40) tick();
`endif
    nop(); mid();
    check("sat stall_cnt", bus.stall_cnt, CNT_MAX);
    tick();
    drain();

    // Reset mid-stream with valid entries, branch and hazard present
    ldr(3, 3); tick(); tick();
    alu(5, 3, 3); ctl(1, 0); rst = 1'b1; mid();
    check("rst stall", bus.stall, 0);
    check("rst flush", bus.flush, 0);
    check("rst fwd_a", bus.fwd_sel_a, 0);
    check("rst fwd_b", bus.fwd_sel_b, 0);
    check("rst stall_cnt", bus.stall_cnt, 0);
    check("rst flush_cnt", bus.flush_cnt, 0);
    tick();
    rst = 1'b0; ctl(0, 0); mid();
    check("post-rst stall", bus.stall, 0);
    tick();
    drain();

    // Randomised traffic; the ID instruction is held while stalled or frozen
    for (int i = 0; i < 2000; i++) begin
      hold     = e_stall || bus.ext_freeze;
      frz_prev = bus.ext_freeze;
      br_prev  = bus.branch_taken;
      rst      = ($urandom_range(0, 149) == 0);
      if (!hold)
        set_id($urandom_range(0, 4) != 0,
               $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3),
               $urandom_range(0, 1) != 0, $urandom_range(0, 3));
      bus.ext_freeze   = ($urandom_range(0, 7) == 0);
      bus.branch_taken = frz_prev ? br_prev : ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

- Parametrised pipeline hazard controller for the ARM core. Successor to the fixed two-stage hazard detector.
- Keeps a shadow scoreboard of in-flight instruction tags, one entry per stage after decode.
- Drives the IF/ID stall, the bubble/flush for the branch path, and operand-forwarding selects for EXE.
- Counts stall and flush cycles for performance measurement.

## Interface
- REG_W, 4, register address width
- DEPTH, 3, tracked post-decode stages (entry 0 = EXE, entry DEPTH-1 = WB); legal range 2..6
- CNT_W, 16, width of the stall and flush counters
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rn  in  REG_W  first source register
- id_src2  in  REG_W  second source register (Rm, or Rd for stores)
- id_two_src  in  1  instruction reads id_src2
- id_uses_rn  in  1  instruction reads id_rn (0 for MOV/MVN/B)
- id_dest  in  REG_W  destination register
- id_wb_en  in  1  instruction writes the register file
- id_mem_r_en  in  1  instruction is a load
- branch_taken  in  1  EXE resolved a taken branch this cycle
- ext_freeze  in  1  global freeze (memory wait); holds the whole pipeline
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EXE
- flush  out  1  clear IF/ID and ID/EXE
- fwd_sel_a  out  2  EXE operand Rn source: 0 = regfile, 1 = MEM-stage ALU result, 2 = WB value
- fwd_sel_b  out  2  EXE operand src2 source, same encoding
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

## Operation
- **Scoreboard entry:** {valid, wb_en, mem_r_en, dest, rn, src2, uses_rn, two_src}.
- **Advance, ext_freeze=0:**
  - entries 1..DEPTH-1 take entries 0..DEPTH-2;
  - entry 0 takes the ID tags if id_valid & !stall & !flush;
  - otherwise entry 0 becomes a bubble (valid=0).
- **ext_freeze=1:** scoreboard, counters and all registered state hold. stall and flush are forced to 0.
- **Hazard match:** a source s matches entry k when valid_k & wb_en_k & dest_k == s, and the source is actually used (uses_rn for rn, two_src for src2).
- **Hazard window:** entries 0..DEPTH-2. The WB entry never causes a hazard, because the regfile writes in the first half-cycle.
- **stall with FORWARD_EN:** asserted only for a load-use case: id_valid & entry 0 matches with mem_r_en_0=1.
- **stall without FORWARD_EN:** asserted on any match in the hazard window.
- **flush = branch_taken.**
  - When flush=1, stall is forced to 0.
  - The ID instruction is killed; it does not enter entry 0.
- **Forward selects** (FORWARD_EN only) use entry 0's sources against the registered entries:
  - entry 1 match with mem_r_en_1=0 → 1;
  - else entry 2 match → 2;
  - else 0.
  - The nearest stage wins.
  - A load in entry 1 never forwards from MEM: the load-use stall has already separated it by one bubble, so it is forwarded from WB.
  - With DEPTH=2, select value 2 is never generated.
- **Counters:** stall_cnt increments on each stall=1 cycle; flush_cnt increments on each flush=1 cycle. Both saturate at all-ones and do not wrap.
- **Register 0:** no special treatment; r0 is an ordinary register.

## Timing
- **Reset values:** every output is 0 and every scoreboard entry has valid=0.
- stall, flush and fwd_sel_* are combinational from the ID inputs plus the registered scoreboard; they are valid in the same cycle.
- The scoreboard and counters update on the rising clk edge.
- A load-use stall lasts exactly 1 cycle with FORWARD_EN.
- **Without FORWARD_EN,** a producer at entry 0 stalls its consumer for DEPTH-1 cycles; with DEPTH=3 that is 2 cycles.
- **branch_taken with a simultaneous hazard:** flush wins; stall=0; stall_cnt does not increment.
- **ext_freeze with branch_taken:** freeze wins; flush is deferred until freeze drops (EXE holds branch_taken).
- **rst mid-operation:** the scoreboard clears immediately (asynchronously); counters return to 0.

## Configuration
- Macro: HAZARD_FORWARD_EN.
- Defined: forwarding logic is present, and stall is restricted to load-use.
- Undefined:
  - fwd_sel_a and fwd_sel_b are tied to 0;
  - stall covers every RAW match in entries 0..DEPTH-2 (the legacy behaviour).

## Test plan
- **Reset:** assert rst mid-stream with entries valid → all outputs 0 the same cycle; stall=0 after release for any ID input.
- **ALU RAW, FORWARD_EN, DEPTH=3:**
  - sequence ADD r1 ← …, then SUB r2 ← r1,r3;
  - required: stall never 1; when SUB is in EXE, fwd_sel_a=1;
  - with one independent instruction between them: fwd_sel_a=2.
- **Load-use, FORWARD_EN:**
  - sequence LDR r4, then ADD r5 ← r4,r4;
  - required: stall=1 for exactly 1 cycle, stall_cnt=1;
  - then ADD in EXE has fwd_sel_a=2 and fwd_sel_b=2.
- **No forwarding (macro undefined), DEPTH=4:**
  - sequence ADD r1 then ORR r6 ← r1;
  - required: stall=1 for 3 cycles, stall_cnt=3, fwd_sel_* stay 0.
- **Branch vs hazard:**
  - branch_taken=1 while the ID instruction is load-dependent;
  - required: flush=1, stall=0, flush_cnt +1, entry 0 becomes a bubble next cycle.
- **Freeze and saturation:**
  - ext_freeze=1 for 5 cycles during a stall → outputs stall=0 and the counters hold;
  - with CNT_W=4, 20 consecutive stall cycles → stall_cnt=15.
